// File: rtl/mem_stream_loader_if.sv
// Byte-stream input and Memory write-port signals shared by the boot loader and its peers.
// The master side is the loader: it consumes the stream and drives the write port.
interface mem_stream_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_en;

    modport master (
        input  in_data, in_valid,
        output in_ready, w_addr, w_data, w_en
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, w_addr, w_data, w_en
    );
endinterface

// File: rtl/mem_stream_loader.sv
// Boot loader: parses a framed big-endian byte stream, writes it into Memory and
// releases the CPU from reset only once the image checksum verifies.
module mem_stream_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int N_ELEMENTS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_stream_loader_if.master  bus,
    input  logic                 restart,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error
);
    typedef enum logic [3:0] {
        ADDR_HI, ADDR_LO, LEN_HI, LEN_LO,
        DATA_HI, DATA_LO, CSUM_HI, CSUM_LO,
        DONE, ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(N_ELEMENTS);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [15:0]           sum;
    logic [7:0]            hi;
    logic                  range_err;

    logic        take;
    logic [15:0] field;

    assign take  = bus.in_valid && bus.in_ready;
    assign field = {hi, bus.in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ADDR_HI;
            addr         <= '0;
            cnt          <= '0;
            sum          <= '0;
            hi           <= '0;
            range_err    <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.w_addr   <= '0;
            bus.w_data   <= '0;
            bus.w_en     <= 1'b0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            bus.w_en <= 1'b0;
            case (state)
                ADDR_HI, LEN_HI, DATA_HI, CSUM_HI: begin
                    if (take) begin
                        hi    <= bus.in_data;
                        state <= state_t'(state + 4'd1);
                    end
                end
                ADDR_LO: begin
                    if (take) begin
                        addr  <= ADDR_WIDTH'(field);
                        state <= LEN_HI;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        cnt   <= ADDR_WIDTH'(field);
                        state <= (field != 16'd0) ? DATA_HI : CSUM_HI;
                    end
                end
                DATA_LO: begin
                    if (take) begin
                        // Out-of-range words still feed the checksum so the frame stays aligned.
                        bus.w_data <= DATA_WIDTH'(field);
                        bus.w_addr <= addr;
                        bus.w_en   <= (addr < ADDR_LIMIT);
                        if (addr >= ADDR_LIMIT) range_err <= 1'b1;
                        addr  <= addr + ONE;
                        sum   <= sum + field;
                        cnt   <= cnt - ONE;
                        state <= (cnt == ONE) ? CSUM_HI : DATA_HI;
                    end
                end
                CSUM_LO: begin
                    if (take) begin
                        bus.in_ready <= 1'b0;
                        if (field == sum && !range_err) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (restart) begin
                        state        <= ADDR_HI;
                        sum          <= '0;
                        range_err    <= 1'b0;
                        bus.in_ready <= 1'b1;
                        cpu_rst      <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                    end
                end
                default: state <= ADDR_HI;
            endcase
        end
    end
endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Write-side initiator for the 2R/1W Memory block: loads a program image into Memory through its write port (w_addr/w_data/w_en).
- Receives the image as a framed byte stream over a valid/ready interface, e.g. from a UART receiver or testbench.
- Holds the CPU in reset until the image is loaded and its checksum verifies.
- Replaces the hard-coded mem_init table as the boot path.

Parameters:
ADDR_WIDTH, 16, width of w_addr, and of the frame's start-address and length fields
DATA_WIDTH, 16, word width; fixed at 16 (two bytes per word)
N_ELEMENTS, 128, number of valid Memory entries; addresses >= N_ELEMENTS are out of range

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
restart  input  1  start a new load; honoured only in DONE or ERR
w_addr  output  ADDR_WIDTH  Memory write address
w_data  output  DATA_WIDTH  Memory write data
w_en  output  1  Memory write enable, one-cycle pulse per word
cpu_rst  output  1  hold the CPU in reset; 1 unless state is DONE
done  output  1  load completed and checksum matched
error  output  1  checksum mismatch or out-of-range address

Behaviour:
- Reset is asynchronous and active-high. One clock.
- Reset values: state=ADDR_HI, in_ready=1, w_en=0, w_addr=0, w_data=0, cpu_rst=1, done=0, error=0. Internal registers (address, count, sum, byte latch, range flag) reset to 0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready=1 in all receive states and 0 in DONE/ERR. No combinational path from in_valid to in_ready.
- Frame format, all fields big-endian (hi byte first):
  - START address word
  - LEN word (count of data words)
  - LEN data words
  - CSUM word = sum of the data words mod 2^16
- States and transitions (each transition occurs on an accepted byte):
  - ADDR_HI -> ADDR_LO -> LEN_HI -> LEN_LO
  - LEN_LO -> DATA_HI if LEN != 0, else -> CSUM_HI
  - DATA_HI -> DATA_LO
  - DATA_LO -> DATA_HI while words remain, else -> CSUM_HI
  - CSUM_HI -> CSUM_LO
  - CSUM_LO -> DONE if checksum matches and no range error, else -> ERR
- Data write:
  - On the edge that accepts the DATA_LO byte, register w_data={hi,lo}, w_addr=current address, and w_en=1 (if in range).
  - w_en is therefore high for the cycle after acceptance; latency is one cycle from the low-byte edge.
  - w_en returns to 0 on the next edge unless another word completes. Back-to-back words give at most one pulse per 2 accepted bytes.
  - After the write, address increments mod 2^ADDR_WIDTH (wraps from all-ones to 0) and sum += word mod 2^16.
- Out of range: if the word's address >= N_ELEMENTS, w_en stays 0 for that word and a sticky range flag is set. The sum still accumulates the word. The frame still completes and ends in ERR.
- LEN=0: no writes; the expected checksum is 0x0000.
- DONE: cpu_rst=0, done=1. Stays until rst or restart.
- ERR: cpu_rst=1, error=1. Stays until rst or restart.
- restart: in DONE/ERR, one cycle -> ADDR_HI with done=0, error=0, cpu_rst=1, and sum and range flag cleared. Ignored in all other states.
- Reset mid-frame: returns to ADDR_HI immediately (asynchronous). Memory words already written remain; w_en drops asynchronously.
- Bubbles (in_valid=0) between bytes are allowed at any point with no timeout; state holds.

Test Plan:
- Basic load: START=0x0010, LEN=2, data 0x1234, 0xABCD, CSUM=0xBE01 -> w_en pulses with (0x0010,0x1234) then (0x0011,0xABCD); done=1, cpu_rst=0, error=0.
- Bad checksum: same frame with CSUM=0xBE00 -> both writes occur; ends in ERR, error=1, cpu_rst=1, in_ready=0.
- Range: START=0x007F, LEN=2, data 0x0001, 0x0002, CSUM=0x0003 -> one write at 0x7F; the second is suppressed; error=1.
- LEN=0 with CSUM=0x0000 -> no w_en, done=1. Then pulse restart -> done=0, in_ready=1, a second frame loads normally.
- Throttling and reset: random in_valid gaps give the same writes as the basic load. Asserting rst after the 5th byte drops cpu_rst to 1, resets state to ADDR_HI, and emits no further w_en.
